// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into CHUNK-bit ripple slices, one register stage per
// slice. The carry moves one slice per cycle, so timing does not scale with WIDTH. Results
// appear STAGES cycles after acceptance. A single global enable stalls the whole pipe when
// the consumer is not ready. Bubbles are not collapsed.
//
// Parameters:
//   WIDTH  operand/sum width, a multiple of CHUNK
//   CHUNK  bits per slice, 1..WIDTH
//
// Ports:
//   clock, reset_n       rising-edge clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, cin)
//   out_valid/out_ready  result handshake (sum, cout, ovf)
//   sum, cout, ovf       result, carry out of MSB, two's-complement overflow
//
// Optional build macro PIPELINED_ADDER_SUB_EN adds input 'sub'. When sub=1 the block
// computes a - b: b is inverted and the carry-in is forced to 1 at the input, so the mode
// bit does not need to travel down the pipe. cout=1 then means no borrow.
module pipelined_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic              en;
  logic [STAGES-1:0] valid_q, valid_d;
  // ld[p]: load enable for every register sitting at time position p (p cycles after accept).
  logic [STAGES-1:0] ld;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic              ovf_q;

`ifdef PIPELINED_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign en        = !(valid_q[STAGES-1] && !out_ready);
  assign in_ready  = en && reset_n;
  assign out_valid = valid_q[STAGES-1];

  // Registers only load when an operation occupies the position feeding them, so output data
  // holds its last value across bubbles as well as stalls.
  always_comb begin
    ld    = '0;
    ld[0] = en & in_valid;
    for (int p = 1; p < STAGES; p++) begin
      ld[p] = en & valid_q[p-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (en) begin
      valid_d[0] = in_valid;
      for (int p = 1; p < STAGES; p++) begin
        valid_d[p] = valid_q[p-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Dsk = STAGES - 1 - k;

    logic [CHUNK-1:0] a_in, b_in;
    logic             c_in;
    logic [CHUNK:0]   add_full;
    logic [CHUNK-1:0] sum_q;
    logic             carry_q;

    if (k == 0) begin : g_first
      assign a_in = a[CHUNK-1:0];
      assign b_in = b_eff[CHUNK-1:0];
      assign c_in = cin_eff;
    end else begin : g_skew
      // Chunk k of the operands waits k cycles so it meets the carry from slice k-1.
      logic [CHUNK-1:0] a_dly_q [k];
      logic [CHUNK-1:0] b_dly_q [k];

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          for (int j = 0; j < k; j++) begin
            a_dly_q[j] <= '0;
            b_dly_q[j] <= '0;
          end
        end else begin
          if (ld[0]) begin
            a_dly_q[0] <= a[k*CHUNK +: CHUNK];
            b_dly_q[0] <= b_eff[k*CHUNK +: CHUNK];
          end
          for (int j = 1; j < k; j++) begin
            if (ld[j]) begin
              a_dly_q[j] <= a_dly_q[j-1];
              b_dly_q[j] <= b_dly_q[j-1];
            end
          end
        end
      end

      assign a_in = a_dly_q[k-1];
      assign b_in = b_dly_q[k-1];
      assign c_in = g_stage[k-1].carry_q;
    end

    assign add_full = {1'b0, a_in} + {1'b0, b_in} + {{CHUNK{1'b0}}, c_in};

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (ld[k]) begin
        sum_q   <= add_full[CHUNK-1:0];
        carry_q <= add_full[CHUNK];
      end
    end

    if (k == STAGES - 1) begin : g_last
      // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
      logic c_msb;
      assign c_msb = a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ add_full[CHUNK-1];

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          ovf_q <= 1'b0;
        end else if (ld[k]) begin
          ovf_q <= c_msb ^ add_full[CHUNK];
        end
      end
    end

    if (Dsk > 0) begin : g_deskew
      // Early chunks wait so every chunk of one result leaves together.
      logic [CHUNK-1:0] dsk_q [Dsk];

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          for (int j = 0; j < Dsk; j++) begin
            dsk_q[j] <= '0;
          end
        end else begin
          if (ld[k+1]) begin
            dsk_q[0] <= sum_q;
          end
          for (int j = 1; j < Dsk; j++) begin
            if (ld[k+1+j]) begin
              dsk_q[j] <= dsk_q[j-1];
            end
          end
        end
      end

      assign sum[k*CHUNK +: CHUNK] = dsk_q[Dsk-1];
    end else begin : g_direct
      assign sum[k*CHUNK +: CHUNK] = sum_q;
    end
  end

  assign cout = g_stage[STAGES-1].carry_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder with WIDTH=16, CHUNK=4 (latency 4).
module tb_pipelined_adder;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  pipelined_adder #(
    .WIDTH(16),
    .CHUNK(4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one operand pair for exactly one accepting edge.
  task automatic launch(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    a = va;
    b = vb;
    cin = vc;
    in_valid = 1'b1;
    #1;
    check("launch_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Called right after the accepting edge; result must show after 3 more edges.
  task automatic wait_result(input string tag, input logic [15:0] es, input logic ec,
                             input logic eo);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_early"}, 32'(out_valid), 32'd0);
      step();
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  // Stream vectors with hand-computed results.
  logic [15:0] sa [8] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1111,
                          16'h7000, 16'hABCD, 16'h00FF, 16'hF0F0};
  logic [15:0] sb [8] = '{16'h0002, 16'h8000, 16'hFFFF, 16'h2222,
                          16'h1000, 16'h1234, 16'h0F01, 16'h0F0F};
  logic        sc [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] es [8] = '{16'h0003, 16'h0000, 16'hFFFF, 16'h3334,
                          16'h8000, 16'hBE01, 16'h1000, 16'h0000};
  logic        ec [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        eo [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        pat [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                            1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  // Full-pipeline vectors.
  logic [15:0] fa [5] = '{16'h0010, 16'h0100, 16'h1000, 16'hF000, 16'h4000};
  logic [15:0] fb [5] = '{16'h0020, 16'h0200, 16'h2000, 16'h2000, 16'h4000};
  logic [15:0] fe [5] = '{16'h0030, 16'h0300, 16'h3000, 16'h1000, 16'h8000};
  logic        fc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        fo [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  int          idx;
  int          rd;
  logic        stall;
  logic [15:0] snap_sum;
  logic        snap_c;
  logic        snap_o;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;

    // Reset state.
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    step();

    // Single op, full carry ripple across all slices.
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_result("t1", 16'h0000, 1'b1, 1'b0);
    step();
    check("t1_gone", 32'(out_valid), 32'd0);

    // Back-to-back pair.
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    step();
    a = 16'h1234; b = 16'h4321; cin = 1'b1;
    step();
    in_valid = 1'b0;
    check("b2b_early", 32'(out_valid), 32'd0);
    step();
    step();
    check("b2b0_valid", 32'(out_valid), 32'd1);
    check("b2b0_sum", 32'(sum), 32'h8000);
    check("b2b0_cout", 32'(cout), 32'd0);
    check("b2b0_ovf", 32'(ovf), 32'd1);
    step();
    check("b2b1_valid", 32'(out_valid), 32'd1);
    check("b2b1_sum", 32'(sum), 32'h5556);
    check("b2b1_cout", 32'(cout), 32'd0);
    check("b2b1_ovf", 32'(ovf), 32'd0);
    step();
    check("b2b_gone", 32'(out_valid), 32'd0);

    // Stream with out_ready toggling.
    idx = 0;
    rd  = 0;
    for (int cyc = 0; cyc < 80 && rd < 8; cyc++) begin
      out_ready = pat[cyc % 12];
      in_valid  = (idx < 8);
      if (idx < 8) begin
        a   = sa[idx];
        b   = sb[idx];
        cin = sc[idx];
      end
      #1;
      check("st_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      stall    = out_valid && !out_ready;
      snap_sum = sum;
      snap_c   = cout;
      snap_o   = ovf;
      if (out_valid && out_ready) begin
        if (rd < 8) begin
          check("st_sum", 32'(sum), 32'(es[rd]));
          check("st_cout", 32'(cout), 32'(ec[rd]));
          check("st_ovf", 32'(ovf), 32'(eo[rd]));
          rd++;
        end else begin
          check("st_extra", 32'(out_valid), 32'd0);
        end
      end
      if (in_valid && in_ready) idx++;
      step();
      if (stall) begin
        check("st_hold_valid", 32'(out_valid), 32'd1);
        check("st_hold_sum", 32'(sum), 32'(snap_sum));
        check("st_hold_cout", 32'(cout), 32'(snap_c));
        check("st_hold_ovf", 32'(ovf), 32'(snap_o));
      end
    end
    in_valid = 1'b0;
    check("st_count", 32'(rd), 32'd8);
    out_ready = 1'b1;
    step();
    check("st_drained", 32'(out_valid), 32'd0);

    // Fill the pipe with the consumer blocked, hold, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = fa[i]; b = fb[i]; cin = 1'b0; in_valid = 1'b1;
      #1;
      check("full_fill_ready", 32'(in_ready), 32'd1);
      step();
    end
    a = fa[4]; b = fb[4]; cin = 1'b0; in_valid = 1'b1;
    #1;
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_sum0", 32'(sum), 32'(fe[0]));
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_sum", 32'(sum), 32'(fe[0]));
      check("hold_cout", 32'(cout), 32'(fc[0]));
    end
    out_ready = 1'b1;
    #1;
    check("drain_in_ready", 32'(in_ready), 32'd1);
    for (int r = 1; r < 5; r++) begin
      step();
      in_valid = 1'b0;
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_sum", 32'(sum), 32'(fe[r]));
      check("drain_cout", 32'(cout), 32'(fc[r]));
      check("drain_ovf", 32'(ovf), 32'(fo[r]));
    end
    step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      a = 16'h1111; b = 16'h0101; cin = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_stale", 32'(out_valid), 32'd0);
    end
    launch(16'h2222, 16'h1111, 1'b0);
    wait_result("post_rst", 16'h3333, 1'b0, 1'b0);
    step();

`ifdef PIPELINED_ADDER_SUB_EN
    // Subtract: cin is ignored, borrow-in forced.
    sub = 1'b1;
    a = 16'h0005; b = 16'h0007; cin = 1'b0; in_valid = 1'b1;
    step();
    a = 16'h8000; b = 16'h0001; cin = 1'b0;
    step();
    in_valid = 1'b0;
    sub = 1'b0;
    step();
    step();
    check("sub0_valid", 32'(out_valid), 32'd1);
    check("sub0_sum", 32'(sum), 32'hFFFE);
    check("sub0_cout", 32'(cout), 32'd0);
    check("sub0_ovf", 32'(ovf), 32'd0);
    step();
    check("sub1_valid", 32'(out_valid), 32'd1);
    check("sub1_sum", 32'(sum), 32'h7FFF);
    check("sub1_cout", 32'(cout), 32'd1);
    check("sub1_ovf", 32'(ovf), 32'd1);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised successor to the 16-bit ripple adder: a WIDTH-bit adder split into CHUNK-bit ripple slices, with one register stage per slice.
- Carry propagates one slice per cycle, so the clock period no longer scales with WIDTH.
- Valid/ready handshake on both sides, plus carry-in, carry-out and signed-overflow outputs.
- Sits between operand producers, such as the ALU operand latch, and result consumers.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits per pipeline slice. Must be at least 1 and at most WIDTH.
- STAGES, WIDTH/CHUNK, derived number of slices, equal to latency in cycles. Not overridable.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset_n, input, 1, synchronous active-low reset, sampled on the rising edge of clock.
- in_valid, input, 1, an operand pair is presented.
- in_ready, output, 1, the block accepts the operand pair this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry into bit 0.
- out_valid, output, 1, a result is presented.
- out_ready, input, 1, the consumer takes the result this cycle.
- sum, output, WIDTH, result bits.
- cout, output, 1, carry out of bit WIDTH-1.
- ovf, output, 1, two's-complement overflow.

Behaviour:
- Reset, while reset_n is low at a rising edge:
  - all stage valid bits cleared; all data, skew and carry registers cleared.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=0 while reset_n is low.
- Reset mid-operation: every in-flight operation is discarded. No result of a pre-reset operation ever appears.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready.
- Stall rule: a global enable en = !(out_valid && !out_ready) advances every stage; in_ready = en and reset_n is high.
  - Bubbles are not collapsed.
  - While en=0, all registers hold and sum, cout, ovf and out_valid stay stable.
- Stage k, for k = 0..STAGES-1:
  - adds chunk k of a and b (bits k*CHUNK .. k*CHUNK+CHUNK-1) plus the carry registered by stage k-1.
  - stage 0 uses cin as its carry.
  - registers the CHUNK sum bits and the chunk carry-out.
- Operand skew: chunk k of a and b travels through k delay registers before entering stage k, so the chunk meets its carry.
- Result deskew: sum chunk k travels through STAGES-1-k delay registers, so all chunks of one result emerge together.
- Latency: a result is presented exactly STAGES cycles after acceptance, provided no stall occurs. Each stall cycle adds one.
- Throughput: one operation per cycle while out_ready=1.
- Ordering: results leave strictly in acceptance order. No loss or duplication across any stall pattern.
- Arithmetic:
  - {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
  - ovf = carry into bit WIDTH-1 XOR cout. The final stage registers the carry into the MSB for this purpose.
- Valid tracking: one valid bit per stage, shifted when en=1. out_valid is the last stage's valid bit.
- Output data is unspecified but stable when out_valid=0; implement it as holding the last value.
- Simultaneous events: when out_valid && out_ready && in_valid in the same cycle, the result leaves and the new operand enters on the same edge.
- CHUNK=WIDTH: a single stage with latency 1, which is the registered form of the 16-bit adder.

Optional Feature:
- Macro: PIPELINED_ADDER_SUB_EN.
- Defined:
  - adds an input port sub, 1 bit, sampled with a and b.
  - when sub=1, the B operand is inverted and the effective carry-in is forced to 1, so the result is a - b. The cin port is ignored in this mode.
  - cout=1 means no borrow.
  - ovf keeps the same formula, giving signed subtract overflow.
  - sub travels with its operation through the pipeline only as far as needed, since the inversion is applied at the input.
- Not defined: no sub port; the block adds only.

Test Plan (WIDTH=16, CHUNK=4, STAGES=4):
- 0xFFFF + 0x0001, cin=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x0000, cout=1, ovf=0.
- 0x7FFF + 0x0001, then 0x1234 + 0x4321 with cin=1, back-to-back -> results on consecutive cycles: 0x8000/cout0/ovf1, then 0x5556/cout0/ovf0.
- Stream of 8 random pairs with out_ready toggling 1,0,0,1,0,1... -> 8 results in order, each equal to the reference sum. in_ready=0 exactly when out_valid && !out_ready. Outputs stable during stalls.
- Pipeline full, out_ready held low 3 cycles -> no accepts and no output change. Then out_ready=1 -> drains one result per cycle.
- 3 operations in flight, reset_n=0 for 1 cycle -> out_valid=0 and sum=0 the next cycle. No pre-reset result ever appears. A new operation afterwards returns in 4 cycles.
- With PIPELINED_ADDER_SUB_EN: 0x0005 - 0x0007 -> 0xFFFE, cout0, ovf0; 0x8000 - 0x0001 -> 0x7FFF, cout1, ovf1.
